// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives select/enable of a 2x4 decoder so the enabled
// channels are strobed in ascending order, each for dwell+1 cycles, with a
// one-cycle enable-low gap between channels. Single-pass or continuous.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         A,
    output logic               E,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [1:0]         state_r, state_s;
    logic [1:0]         a_r, a_s;
    logic               e_r, e_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               wrap_r, wrap_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [DWELL_W-1:0] dwell_r, dwell_s;
    logic [3:0]         mask_r, mask_s;
    logic               mode_r, mode_s;
    logic [2:0]         nxt_s;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                ch = i[1:0];
            end else begin
                ch = ch;
            end
        end
        return ch;
    endfunction

    // Next enabled channel above cur; falls back to the lowest one.
    // Result is {wrapped, channel}.
    function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic       found;
        logic [1:0] ch;
        found = 1'b0;
        ch    = lowest_ch(m);
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) begin
                found = 1'b1;
                ch    = i[1:0];
            end else begin
                found = found;
            end
        end
        return {~found, ch};
    endfunction

    assign A    = a_r;
    assign E    = e_r;
    assign busy = busy_r;
    assign done = done_r;
    assign wrap = wrap_r;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        e_s     = e_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        wrap_s  = 1'b0;
        cnt_s   = cnt_r;
        dwell_s = dwell_r;
        mask_s  = mask_r;
        mode_s  = mode_r;
        nxt_s   = next_ch(mask_r, a_r);
        if (stop) begin
            state_s = ST_IDLE;
            a_s     = 2'd0;
            e_s     = 1'b0;
            busy_s  = 1'b0;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (mask != 4'b0000)) begin
                        state_s = ST_ACTIVE;
                        a_s     = lowest_ch(mask);
                        e_s     = 1'b1;
                        busy_s  = 1'b1;
                        cnt_s   = '0;
                        dwell_s = dwell;
                        mask_s  = mask;
                        mode_s  = mode;
                    end else begin
                        a_s    = 2'd0;
                        e_s    = 1'b0;
                        busy_s = 1'b0;
                        cnt_s  = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_r == dwell_r) begin
                        cnt_s = '0;
                        e_s   = 1'b0;
                        if (nxt_s[2] && mode_r) begin
                            // Last channel of a single pass: straight back to idle.
                            state_s = ST_IDLE;
                            a_s     = 2'd0;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_GAP;
                            a_s     = nxt_s[1:0];
                            wrap_s  = nxt_s[2];
                        end
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_s = ST_ACTIVE;
                    e_s     = 1'b1;
                    cnt_s   = '0;
                end
                default: begin
                    state_s = ST_IDLE;
                    a_s     = 2'd0;
                    e_s     = 1'b0;
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything including E at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= 2'd0;
            e_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
            cnt_r   <= '0;
            dwell_r <= '0;
            mask_r  <= 4'b0000;
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            e_r     <= e_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            wrap_r  <= wrap_s;
            cnt_r   <= cnt_s;
            dwell_r <= dwell_s;
            mask_r  <= mask_s;
            mode_r  <= mode_s;
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl. Expected per-cycle outputs come
// from a schedule built out of the list of enabled channels.
module tb_decoder_scan_ctrl;

    typedef struct packed {
        logic [1:0] a;
        logic       e;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [7:0] dwell = 8'd0;
    logic [1:0] A;
    logic       E, busy, done, wrap;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t obs;

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .mask(mask), .dwell(dwell), .A(A), .E(E), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    always_comb obs = '{a: A, e: E, busy: busy, done: done, wrap: wrap};

    // Build the expected outputs for cycles 1..n after an accepted start.
    task automatic build_sched(input logic [3:0] m, input int d, input logic md, input int n);
        int   chans[$];
        int   idx;
        bit   last;
        exp_t idle_e;
        idle_e = '{a: 2'd0, e: 1'b0, busy: 1'b0, done: 1'b0, wrap: 1'b0};
        exp_q.delete();
        for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
        idx = 0;
        while (exp_q.size() < n) begin
            if (chans.size() == 0) begin
                exp_q.push_back(idle_e);
            end else begin
                for (int k = 0; k <= d; k++)
                    exp_q.push_back('{a: 2'(chans[idx]), e: 1'b1, busy: 1'b1, done: 1'b0, wrap: 1'b0});
                last = (idx == chans.size() - 1);
                if (last && md) begin
                    exp_q.push_back('{a: 2'd0, e: 1'b0, busy: 1'b0, done: 1'b1, wrap: 1'b0});
                    while (exp_q.size() < n) exp_q.push_back(idle_e);
                end else begin
                    idx = last ? 0 : idx + 1;
                    exp_q.push_back('{a: 2'(chans[idx]), e: 1'b0, busy: 1'b1, done: 1'b0, wrap: last});
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b (A,E,busy,done,wrap)", obs, 6'b0);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    // Single passes: the fixed all-channel case and randomized ones.
    task automatic test_single_pass();
        for (int r = 0; r < 6; r++) begin
            int n;
            if (r == 0) begin
                mask = 4'b1111; dwell = 8'd2;
            end else begin
                mask = 4'($urandom_range(1, 15)); dwell = 8'($urandom_range(0, 4));
            end
            mode = 1'b1;
            n = 4 * (int'(dwell) + 2) + 2;
            build_sched(mask, int'(dwell), 1'b1, n);
            start = 1'b1;
            for (int c = 1; c <= n; c++) begin
                next_cycle();
                start = 1'b0;
                checks++;
                if (obs !== exp_q[c-1]) begin
                    errors++;
                    $display("FAIL single_pass r%0d mask=%b dwell=%0d cycle %0d: got %b expected %b",
                             r, mask, dwell, c, obs, exp_q[c-1]);
                end
            end
        end
    endtask

    // Continuous scanning then stop, plus stop overriding start in idle.
    task automatic test_continuous_stop();
        for (int r = 0; r < 5; r++) begin
            int stop_at;
            if (r == 0) begin
                mask = 4'b1010; dwell = 8'd0; stop_at = 6;
            end else begin
                mask = 4'($urandom_range(1, 15)); dwell = 8'($urandom_range(0, 3));
                stop_at = $urandom_range(3, 25);
            end
            mode = 1'b0;
            build_sched(mask, int'(dwell), 1'b0, stop_at);
            start = 1'b1;
            for (int c = 1; c <= stop_at + 2; c++) begin
                next_cycle();
                start = 1'b0;
                stop  = (c == stop_at);
                checks++;
                if (c <= stop_at) begin
                    if (obs !== exp_q[c-1]) begin
                        errors++;
                        $display("FAIL continuous r%0d mask=%b dwell=%0d cycle %0d: got %b expected %b",
                                 r, mask, dwell, c, obs, exp_q[c-1]);
                    end
                end else if (obs !== 6'b0) begin
                    errors++;
                    $display("FAIL after_stop r%0d cycle %0d: got %b expected %b", r, c, obs, 6'b0);
                end
            end
        end
        start = 1'b1; stop = 1'b1; mask = 4'b1111;
        next_cycle();
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL start_with_stop cycle %0d: got %b expected %b", c, obs, 6'b0);
            end
        end
    endtask

    // Empty mask is ignored; a single channel pass still completes.
    task automatic test_zero_mask();
        mask = 4'b0000; dwell = 8'd2; mode = 1'b1; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            start = 1'b0;
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL zero_mask cycle %0d: got %b expected %b", c, obs, 6'b0);
            end
        end
        mask = 4'b0100; dwell = 8'd3; mode = 1'b1;
        build_sched(mask, 3, 1'b1, 6);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start = 1'b0;
            checks++;
            if (obs !== exp_q[c-1]) begin
                errors++;
                $display("FAIL one_channel cycle %0d: got %b expected %b", c, obs, exp_q[c-1]);
            end
        end
    endtask

    // Input changes and start while busy are ignored; start on done restarts.
    task automatic test_back_to_back();
        mask = 4'b1111; dwell = 8'd2; mode = 1'b1;
        build_sched(4'b1111, 2, 1'b1, 16);
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            checks++;
            if (obs !== exp_q[c-1]) begin
                errors++;
                $display("FAIL busy_ignore cycle %0d: got %b expected %b", c, obs, exp_q[c-1]);
            end
            if (c == 2) begin
                mask = 4'b0001; dwell = 8'd7;
            end
            start = (c == 6) || (c == 16);
        end
        build_sched(4'b0001, 7, 1'b1, 10);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            start = 1'b0;
            checks++;
            if (obs !== exp_q[c-1]) begin
                errors++;
                $display("FAIL restart_on_done cycle %0d: got %b expected %b", c, obs, exp_q[c-1]);
            end
        end
    endtask

    // Reset pulse between clock edges while a channel is on.
    task automatic test_async_reset();
        mask = 4'b0110; dwell = 8'd5; mode = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        checks++;
        if (E !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_active: got E=%b busy=%b expected E=1 busy=1", E, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, 6'b0);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: got %b expected %b", c, obs, 6'b0);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_pass();
        test_continuous_stop();
        test_zero_mask();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 2x4 decoder. It drives the decoder's 2-bit select and enable so the four one-hot outputs are strobed in turn.
- Per-channel dwell time is programmable, and disabled channels are skipped.
- Break-before-make: a one-cycle gap with enable low separates every channel change, so two decoder outputs are never active in the same cycle.
- Runs either one pass over the enabled channels or continuously until stopped.

Parameters:
DWELL_W, 8, width of the dwell count; each channel is on for dwell+1 cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  begin scan; sampled only in IDLE
stop  input  1  abort scan; sampled in every state; priority over start
mode  input  1  0 = continuous, 1 = single pass; latched on accepted start
mask  input  4  channel enables, bit i = channel i; latched on accepted start
dwell  input  DWELL_W  on-time minus one; latched on accepted start
A  output  2  decoder select (registered)
E  output  1  decoder enable (registered)
busy  output  1  high in ACTIVE and GAP
done  output  1  one-cycle pulse at end of a single pass
wrap  output  1  one-cycle pulse when A wraps to the lowest enabled channel (continuous mode)

Behaviour:
- Reset (async, any time): state IDLE, A=0, E=0, busy=0, done=0, wrap=0, internal dwell counter=0.
- All outputs are registered. No combinational path exists from any input to any output.
- States are IDLE, ACTIVE and GAP.
- Idle outputs: A=0, E=0, busy=0.
- Accepting start:
  - start=1 and mask!=0 in IDLE: next cycle the block enters ACTIVE with A = lowest set mask bit, E=1, busy=1, counter=0.
  - start with mask=0000 is ignored: block stays IDLE, no done pulse.
- ACTIVE: E=1 and the counter increments each cycle.
  - When counter==dwell_latched, the next cycle goes to GAP with E=0 and A = next channel.
  - A channel is therefore on for exactly dwell+1 cycles.
- Next channel:
  - Lowest set latched-mask bit above current A.
  - If none exists, the lowest set bit overall (a wrap).
  - With a single enabled channel, the next channel equals current A.
- Single pass (mode=1), end of the last enabled channel: next cycle is IDLE, not GAP, with E=0, A=0, busy=0, done=1 for one cycle. wrap stays 0.
- Continuous (mode=1 cleared, i.e. mode=0): scanning continues indefinitely. In the GAP cycle where A wraps, wrap=1 for that cycle only.
- GAP: lasts exactly one cycle with E=0, busy=1. Next cycle goes to ACTIVE with E=1, counter=0.
- stop=1 in ACTIVE or GAP: next cycle IDLE, E=0, A=0, busy=0, done=0, wrap=0.
- stop=1 in IDLE: no effect; stop overrides a coincident start.
- Ignored inputs:
  - start while busy is ignored.
  - mask, dwell and mode changes while busy have no effect until the next accepted start.
- Back-to-back passes: start is accepted in the IDLE cycle where done=1, giving a fresh pass with no extra idle cycle.
- Reset asserted mid-scan forces E=0 immediately, without waiting for a clock edge.
- Invariant: E=1 only in ACTIVE, and A never changes in a cycle where E=1 at either edge (A changes only on entry to GAP or IDLE).

Test Plan:
1. Reset, then mask=1111, dwell=2, mode=1, start pulse at cycle 0:
   - A=0 E=1 in cycles 1-3; gap cycle 4 with A=1 E=0.
   - Ch1 in cycles 5-7, gap 8, ch2 9-11, gap 12, ch3 13-15.
   - Cycle 16: E=0, A=0, busy=0, done=1; done=0 at cycle 17.
2. mask=1010, dwell=0, mode=0, start at cycle 0:
   - A=1 E=1 cycle 1; gap cycle 2 A=3; A=3 E=1 cycle 3.
   - Gap cycle 4 A=1 with wrap=1; A=1 E=1 cycle 5; pattern repeats, done never asserts.
3. Test 2 running, stop=1 asserted at cycle 6:
   - Cycle 7: E=0, A=0, busy=0, wrap=0, done=0.
   - start=1 together with stop=1 in IDLE: block stays IDLE.
4. start with mask=0000: busy, E and done stay 0 for 20 cycles. start with mask=0100, dwell=3, mode=1: A=2 E=1 cycles 1-4, done=1 cycle 5.
5. Test 1 running:
   - Change mask to 0001 and dwell to 7 at cycle 2: sequence is unchanged from test 1.
   - start pulse at cycle 6 is ignored.
   - start held high at cycle 16 (done=1): new pass with A=0 E=1 from cycle 17.
6. Async rst pulse mid-cycle during ACTIVE (E=1): E, busy and A go to 0 before the next clock edge. After release, the block stays IDLE until start.
